// File: rtl/reg_bank_reader.sv
// Burst reader for a flattened register bank.
// A request (start address + length) is accepted in IDLE. The reader then streams
// consecutive registers out on a valid/ready port, one beat per cycle. Each beat is
// a registered snapshot of the bank, so it stays stable while the consumer stalls.
// Addresses wrap from NUM_REGS-1 back to 0. A start address outside the bank is
// remapped to 0.
module reg_bank_reader #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int LEN_W    = 3
) (
    input  logic                         clk_i,
    input  logic                         clr_n_i,
    input  logic [NUM_REGS*DATA_W-1:0]   bank_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [LEN_W-1:0]             req_len_i,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    output logic                         rd_last_o,
    output logic                         busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [LEN_W-1:0]    remaining_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_valid_q;
    logic                rd_last_q;

    // Per-register view of the flattened bank so it can be indexed by address.
    logic [DATA_W-1:0]   bank_words [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign bank_words[gi] = bank_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [ADDR_W-1:0]   start_addr_d;
    logic [ADDR_W-1:0]   next_addr_d;

    // An out-of-range start address reads from register 0.
    assign start_addr_d = (req_addr_i > LAST_ADDR) ? '0 : req_addr_i;
    // The address after the current beat wraps around the end of the bank.
    assign next_addr_d  = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == BURST);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_last_o   = rd_last_q;

    // Burst sequencer: accept a request, then advance one register per consumed beat.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        rd_data_q   <= bank_words[start_addr_d];
                        rd_addr_q   <= start_addr_d;
                        rd_valid_q  <= 1'b1;
                        rd_last_q   <= (req_len_i == '0);
                        remaining_q <= req_len_i;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    // A stalled beat holds its snapshot; nothing changes until it is taken.
                    if (rd_valid_q && rd_ready_i) begin
                        if (rd_last_q) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            rd_addr_q   <= next_addr_d;
                            rd_data_q   <= bank_words[next_addr_d];
                            remaining_q <= remaining_q - LEN_W'(1);
                            rd_last_q   <= (remaining_q == LEN_W'(1));
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader. Two instances share the request/read handshake:
// dut8 has 8 registers, dut6 has 6 registers (for the non-power-of-two wrap case).
module tb_reg_bank_reader;

    logic        clk;
    logic        clr_n;
    logic [63:0] bank;
    logic        req_valid;
    logic [2:0]  req_addr;
    logic [2:0]  req_len;
    logic        rd_ready;

    logic        req_ready8, rd_valid8, rd_last8, busy8;
    logic [7:0]  rd_data8;
    logic [2:0]  rd_addr8;

    logic        req_ready6, rd_valid6, rd_last6, busy6;
    logic [7:0]  rd_data6;
    logic [2:0]  rd_addr6;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_reader #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(3), .LEN_W(3)) dut8 (
        .clk_i       (clk),
        .clr_n_i     (clr_n),
        .bank_i      (bank),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready8),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .rd_valid_o  (rd_valid8),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data8),
        .rd_addr_o   (rd_addr8),
        .rd_last_o   (rd_last8),
        .busy_o      (busy8)
    );

    reg_bank_reader #(.NUM_REGS(6), .DATA_W(8), .ADDR_W(3), .LEN_W(3)) dut6 (
        .clk_i       (clk),
        .clr_n_i     (clr_n),
        .bank_i      (bank[47:0]),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready6),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .rd_valid_o  (rd_valid6),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data6),
        .rd_addr_o   (rd_addr6),
        .rd_last_o   (rd_last6),
        .busy_o      (busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [7:0] val);
        bank[idx*8 +: 8] = val;
    endtask

    task automatic fill_default();
        for (int i = 0; i < 8; i++) bank[i*8 +: 8] = 8'h10 + 8'(i);
    endtask

    initial begin
        clr_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        rd_ready  = 1'b0;
        fill_default();
        #1;
        // Reset state
        check("rst_rd_valid",  32'(rd_valid8),  32'd0);
        check("rst_rd_last",   32'(rd_last8),   32'd0);
        check("rst_busy",      32'(busy8),      32'd0);
        check("rst_req_ready", 32'(req_ready8), 32'd1);
        check("rst_rd_data",   32'(rd_data8),   32'd0);
        check("rst_rd_addr",   32'(rd_addr8),   32'd0);
        tick();
        clr_n = 1'b1;
        tick();

        // Single read of reg5
        set_reg(5, 8'hA5);
        req_valid = 1'b1; req_addr = 3'd5; req_len = 3'd0;
        tick();
        req_valid = 1'b0;
        check("single_valid",     32'(rd_valid8),  32'd1);
        check("single_data",      32'(rd_data8),   32'hA5);
        check("single_addr",      32'(rd_addr8),   32'd5);
        check("single_last",      32'(rd_last8),   32'd1);
        check("single_busy",      32'(busy8),      32'd1);
        check("single_req_ready", 32'(req_ready8), 32'd0);
        rd_ready = 1'b1;
        tick();
        check("single_done_valid", 32'(rd_valid8),  32'd0);
        check("single_done_last",  32'(rd_last8),   32'd0);
        check("single_done_ready", 32'(req_ready8), 32'd1);
        check("single_done_data",  32'(rd_data8),   32'hA5);
        rd_ready = 1'b0;

        // Burst with wrap: addr 6, len 3 -> 6,7,0,1
        fill_default();
        rd_ready = 1'b1;
        req_valid = 1'b1; req_addr = 3'd6; req_len = 3'd3;
        tick();
        req_valid = 1'b0;
        begin
            logic [2:0] exp_addr [4];
            exp_addr[0] = 3'd6; exp_addr[1] = 3'd7; exp_addr[2] = 3'd0; exp_addr[3] = 3'd1;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("wrap_valid%0d", k), 32'(rd_valid8), 32'd1);
                check($sformatf("wrap_addr%0d", k),  32'(rd_addr8),  32'(exp_addr[k]));
                check($sformatf("wrap_data%0d", k),  32'(rd_data8),  32'(8'h10 + 8'(exp_addr[k])));
                check($sformatf("wrap_last%0d", k),  32'(rd_last8),  32'(k == 3));
                tick();
            end
        end
        check("wrap_end_valid", 32'(rd_valid8), 32'd0);
        rd_ready = 1'b0;

        // Backpressure snapshot: reg2 changes while the beat is stalled
        set_reg(2, 8'h22); set_reg(3, 8'h33);
        req_valid = 1'b1; req_addr = 3'd2; req_len = 3'd1;
        tick();
        req_valid = 1'b0;
        set_reg(2, 8'h99);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_data%0d", k),  32'(rd_data8),  32'h22);
            check($sformatf("bp_hold_valid%0d", k), 32'(rd_valid8), 32'd1);
            tick();
        end
        check("bp_hold_last", 32'(rd_last8), 32'd0);
        set_reg(3, 8'h3C);
        rd_ready = 1'b1;
        tick();
        check("bp_beat2_data", 32'(rd_data8), 32'h3C);
        check("bp_beat2_addr", 32'(rd_addr8), 32'd3);
        check("bp_beat2_last", 32'(rd_last8), 32'd1);
        tick();
        check("bp_end_valid", 32'(rd_valid8), 32'd0);

        // Six-register bank, out-of-range start 7, len 6 -> 0,1,2,3,4,5,0
        fill_default();
        req_valid = 1'b1; req_addr = 3'd7; req_len = 3'd6;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            logic [2:0] ea;
            ea = (k == 6) ? 3'd0 : 3'(k);
            check($sformatf("r6_valid%0d", k), 32'(rd_valid6), 32'd1);
            check($sformatf("r6_addr%0d", k),  32'(rd_addr6),  32'(ea));
            check($sformatf("r6_data%0d", k),  32'(rd_data6),  32'(8'h10 + 8'(ea)));
            check($sformatf("r6_last%0d", k),  32'(rd_last6),  32'(k == 6));
            tick();
        end
        check("r6_end_valid", 32'(rd_valid6), 32'd0);

        // Request held while busy: accepted in the first IDLE cycle
        req_valid = 1'b1; req_addr = 3'd1; req_len = 3'd1;
        tick();
        req_addr = 3'd4; req_len = 3'd0;
        check("hold_b1_addr",  32'(rd_addr8),   32'd1);
        check("hold_b1_ready", 32'(req_ready8), 32'd0);
        tick();
        check("hold_b2_addr",  32'(rd_addr8),   32'd2);
        check("hold_b2_last",  32'(rd_last8),   32'd1);
        check("hold_b2_ready", 32'(req_ready8), 32'd0);
        tick();
        check("hold_bubble_valid", 32'(rd_valid8),  32'd0);
        check("hold_bubble_ready", 32'(req_ready8), 32'd1);
        tick();
        req_valid = 1'b0;
        check("hold_b3_valid", 32'(rd_valid8), 32'd1);
        check("hold_b3_addr",  32'(rd_addr8),  32'd4);
        check("hold_b3_data",  32'(rd_data8),  32'h14);
        check("hold_b3_last",  32'(rd_last8),  32'd1);
        tick();
        check("hold_end_valid", 32'(rd_valid8), 32'd0);
        rd_ready = 1'b0;

        // Reset in the middle of a burst, between clock edges
        req_valid = 1'b1; req_addr = 3'd0; req_len = 3'd5;
        tick();
        req_valid = 1'b0;
        check("mrst_pre_valid", 32'(rd_valid8), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("mrst_valid",     32'(rd_valid8),  32'd0);
        check("mrst_busy",      32'(busy8),      32'd0);
        check("mrst_data",      32'(rd_data8),   32'd0);
        check("mrst_addr",      32'(rd_addr8),   32'd0);
        check("mrst_req_ready", 32'(req_ready8), 32'd1);
        tick();
        clr_n = 1'b1;
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mrst_after_valid%0d", k), 32'(rd_valid8), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
